alu_regfile_core: RTL and testbench

Parametrised successor to the team's single-cycle 8-bit ALU. Adds a NREGS-entry register file and valid/ready handshakes on the instruction and result streams. Produces a status flag vector and supports a multi-cycle shift-add multiplier. Sits between an instruction sequencer (upstream) and a result sink/trace logger (downstream).

---
 rtl/alu_pkg.sv | 33 +++
 rtl/seq_multiplier.sv | 65 ++++++
 rtl/alu_regfile_core.sv | 216 +++++++++++++++++++++
 tb/tb_alu_regfile_core.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Brief   : Opcodes, flag bit positions and FSM states for alu_regfile_core.
// Rev     : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MOV  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module : seq_multiplier
// Brief  : Unsigned shift-add multiplier, WIDTH steps, 2*WIDTH-bit product.
// Rev    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    // Step 0 is folded into the start edge so the product is final after
    // WIDTH-1 further edges; 'last' flags the cycle of the final step.
    assign last    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign done    = r_done;
    assign product = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            r_mcand  <= {{WIDTH{1'b0}}, a} << 1;
            r_mplier <= b >> 1;
            r_cnt    <= CW'(1);
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_regfile_core.sv
`default_nettype none
// ============================================================================
// Module : alu_regfile_core
// Brief  : ALU with register file, valid/ready streams and sequential multiply.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_regfile_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS),
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [RW-1:0]    out_rd,
    output logic             out_err,
    output logic             busy
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_regs [NREGS];
    logic [RW-1:0]      r_mul_rd;
    logic               r_busy;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_result;
    logic [3:0]         r_out_flags;
    logic [RW-1:0]      r_out_rd;
    logic               r_out_err;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SW-1:0]      w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;
    logic               w_accept;
    logic               w_single;
    logic               w_mul_start;
    logic               w_mul_last;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_wb;
    logic [3:0]         w_mul_flags;
    logic               w_we;
    logic [RW-1:0]      w_wa;
    logic [WIDTH-1:0]   w_wd;

    assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_rd     = r_out_rd;
    assign out_err    = r_out_err;
    assign busy       = r_busy;

    assign w_a     = r_regs[in_rs1];
    assign w_b     = in_use_imm ? in_imm : r_regs[in_rs2];
    assign w_shamt = w_b[SW-1:0];
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff  = {1'b0, w_a} - {1'b0, w_b};

    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (in_op == OP_MUL);
    assign w_single    = w_accept && (in_op != OP_MUL);
    assign w_mul_wb    = (r_state == DONE) && w_mul_done && (!r_out_valid || out_ready);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (in_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra MSB of the difference is the unsigned borrow.
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_SHL:  w_res = w_a << w_shamt;
            OP_SHR:  w_res = w_a >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(w_a) >>> w_shamt);
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            OP_MOV:  w_res = w_b;
            OP_MUL:  w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_flags = '0;
        if (!w_err) begin
            w_flags[FLG_Z] = (w_res == '0);
            w_flags[FLG_N] = w_res[WIDTH-1];
            w_flags[FLG_C] = w_c;
            w_flags[FLG_V] = w_v;
        end
    end

    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_prod[WIDTH-1:0] == '0);
        w_mul_flags[FLG_N] = w_prod[WIDTH-1];
        w_mul_flags[FLG_C] = |w_prod[2*WIDTH-1:WIDTH];
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (w_a),
        .b       (w_b),
        .last    (w_mul_last),
        .done    (w_mul_done),
        .product (w_prod)
    );

    assign w_we = (w_single && !w_err) || w_mul_wb;
    assign w_wa = w_mul_wb ? r_mul_rd : in_rd;
    assign w_wd = w_mul_wb ? w_prod[WIDTH-1:0] : w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_wa] <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_mul_rd     <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_rd     <= '0;
            r_out_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mul_start) begin
                        r_state  <= MUL;
                        r_busy   <= 1'b1;
                        r_mul_rd <= in_rd;
                    end
                end
                MUL: begin
                    if (w_mul_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_mul_wb) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Loads only happen when the output slot is free or retiring,
            // so a simultaneous handshake keeps out_valid high.
            if (w_single) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_res;
                r_out_flags  <= w_flags;
                r_out_rd     <= in_rd;
                r_out_err    <= w_err;
            end else if (w_mul_wb) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_prod[WIDTH-1:0];
                r_out_flags  <= w_mul_flags;
                r_out_rd     <= r_mul_rd;
                r_out_err    <= 1'b0;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_core.sv
`default_nettype none
// Directed testbench for alu_regfile_core (WIDTH=8, NREGS=8).
`timescale 1ns/1ps
module tb_alu_regfile_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [2:0] out_rd;
    logic       out_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] obs;
    assign obs = {out_valid, out_err, out_rd, out_flags, out_result};

    always #5 clk = ~clk;

    alu_regfile_core #(.WIDTH(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_rd     (out_rd),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Expected output bundle {valid, err, rd, flags{Z,N,C,V}, result}
    function automatic logic [16:0] ex(input logic v, input logic e, input logic [2:0] rd,
                                       input logic [3:0] f, input logic [7:0] r);
        return {v, e, rd, f, r};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm, input logic ui);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL reset_out: got %h expected %h", obs, 17'h0);
        end
        n_checks++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_busy_ready: got %b expected 01", {busy, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(4'd9, 3'd1, 3'd0, 3'd0, 8'd10, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 1, 4'b0000, 8'd10)) begin
            n_fail++; $display("FAIL mov_r1: got %h expected %h", obs, ex(1, 0, 1, 4'b0000, 8'd10));
        end
        drive(4'd9, 3'd2, 3'd0, 3'd0, 8'd5, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 2, 4'b0000, 8'd5)) begin
            n_fail++; $display("FAIL mov_r2: got %h expected %h", obs, ex(1, 0, 2, 4'b0000, 8'd5));
        end
        drive(4'd0, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 3, 4'b0000, 8'd15)) begin
            n_fail++; $display("FAIL add_r3: got %h expected %h", obs, ex(1, 0, 3, 4'b0000, 8'd15));
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid_drop: got %b expected 0", out_valid);
        end
        drive(4'd9, 3'd7, 3'd0, 3'd3, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b0000, 8'd15)) begin
            n_fail++; $display("FAIL read_r3: got %h expected %h", obs, ex(1, 0, 7, 4'b0000, 8'd15));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_arith();
        drive(4'd1, 3'd4, 3'd2, 3'd1, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 4, 4'b0110, 8'hFB)) begin
            n_fail++; $display("FAIL sub_neg: got %h expected %h", obs, ex(1, 0, 4, 4'b0110, 8'hFB));
        end
        drive(4'd1, 3'd7, 3'd1, 3'd0, 8'd10, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b1000, 8'd0)) begin
            n_fail++; $display("FAIL sub_zero: got %h expected %h", obs, ex(1, 0, 7, 4'b1000, 8'd0));
        end
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'd127, 1'b1);
        step();
        drive(4'd0, 3'd7, 3'd6, 3'd0, 8'd1, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b0101, 8'h80)) begin
            n_fail++; $display("FAIL add_ovf: got %h expected %h", obs, ex(1, 0, 7, 4'b0101, 8'h80));
        end
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'd200, 1'b1);
        step();
        drive(4'd0, 3'd7, 3'd6, 3'd0, 8'd100, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b0010, 8'd44)) begin
            n_fail++; $display("FAIL add_carry: got %h expected %h", obs, ex(1, 0, 7, 4'b0010, 8'd44));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_logic_shift();
        // Register state here: r1=10, r2=5, r4=0xFB
        logic [3:0] t_op  [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd5};
        logic [2:0] t_rs1 [12] = '{3'd4, 3'd1, 3'd1, 3'd4, 3'd1, 3'd4, 3'd4, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2};
        logic [7:0] t_imm [12] = '{8'h0F, 8'd5, 8'd10, 8'd0, 8'd9, 8'd2, 8'd2, 8'd7, 8'd10, 8'd5, 8'd10, 8'd7};
        logic [7:0] t_res [12] = '{8'h0B, 8'h0F, 8'h00, 8'hFB, 8'h14, 8'h3E, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80};
        logic [3:0] t_flg [12] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0000,
                                   4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0100};
        for (int i = 0; i < 12; i++) begin
            drive(t_op[i], 3'd7, t_rs1[i], 3'd0, t_imm[i], 1'b1);
            step();
            n_checks++;
            if (obs !== ex(1, 0, 7, t_flg[i], t_res[i])) begin
                n_fail++;
                $display("FAIL logic_shift[%0d] op%0d: got %h expected %h", i, t_op[i], obs,
                         ex(1, 0, 7, t_flg[i], t_res[i]));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        int cyc;
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'd13, 1'b1);
        step();
        drive(4'd10, 3'd5, 3'd6, 3'd0, 8'd11, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b010) begin
            n_fail++; $display("FAIL mul_accept: got %b expected 010", {out_valid, busy, in_ready});
        end
        for (int k = 1; k < 8; k++) begin
            step();
            n_checks++;
            if ({out_valid, busy, in_ready} !== 3'b010) begin
                n_fail++;
                $display("FAIL mul_wait[%0d]: got %b expected 010", k, {out_valid, busy, in_ready});
            end
        end
        step();
        n_checks++;
        if (obs !== ex(1, 0, 5, 4'b0100, 8'd143)) begin
            n_fail++; $display("FAIL mul_13x11: got %h expected %h", obs, ex(1, 0, 5, 4'b0100, 8'd143));
        end
        n_checks++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mul_end_busy: got %b expected 01", {busy, in_ready});
        end
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'd16, 1'b1);
        step();
        drive(4'd10, 3'd5, 3'd6, 3'd0, 8'd16, 1'b1);
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc !== 8) begin
            n_fail++; $display("FAIL mul_latency: got %0d expected 8", cyc);
        end
        n_checks++;
        if (obs !== ex(1, 0, 5, 4'b1010, 8'd0)) begin
            n_fail++; $display("FAIL mul_16x16: got %h expected %h", obs, ex(1, 0, 5, 4'b1010, 8'd0));
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(4'd0, 3'd7, 3'd1, 3'd0, 8'd1, 1'b1);
        step();
        out_ready = 1'b0;
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'h33, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({in_ready, obs} !== {1'b0, ex(1, 0, 7, 4'b0000, 8'd11)}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h expected %h", k, {in_ready, obs},
                         {1'b0, ex(1, 0, 7, 4'b0000, 8'd11)});
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== ex(1, 0, 6, 4'b0000, 8'h33)) begin
            n_fail++; $display("FAIL retire_accept: got %h expected %h", obs, ex(1, 0, 6, 4'b0000, 8'h33));
        end
    endtask

    task automatic test_illegal();
        drive(4'd11, 3'd2, 3'd1, 3'd1, 8'h55, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 1, 2, 4'b0000, 8'd0)) begin
            n_fail++; $display("FAIL illegal_11: got %h expected %h", obs, ex(1, 1, 2, 4'b0000, 8'd0));
        end
        drive(4'd14, 3'd1, 3'd2, 3'd2, 8'hAA, 1'b1);
        step();
        n_checks++;
        if (obs !== ex(1, 1, 1, 4'b0000, 8'd0)) begin
            n_fail++; $display("FAIL illegal_14: got %h expected %h", obs, ex(1, 1, 1, 4'b0000, 8'd0));
        end
        drive(4'd9, 3'd6, 3'd0, 3'd1, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 6, 4'b0000, 8'd10)) begin
            n_fail++; $display("FAIL r1_kept: got %h expected %h", obs, ex(1, 0, 6, 4'b0000, 8'd10));
        end
        drive(4'd9, 3'd6, 3'd0, 3'd2, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 6, 4'b0000, 8'd5)) begin
            n_fail++; $display("FAIL r2_kept: got %h expected %h", obs, ex(1, 0, 6, 4'b0000, 8'd5));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int ghost;
        drive(4'd9, 3'd6, 3'd0, 3'd0, 8'd3, 1'b1);
        step();
        drive(4'd10, 3'd5, 3'd6, 3'd0, 8'd3, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_mul_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, obs} !== 18'h0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", {busy, obs});
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        ghost = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid || busy) ghost++;
        end
        n_checks++;
        if (ghost !== 0) begin
            n_fail++; $display("FAIL no_ghost: got %0d active cycles expected 0", ghost);
        end
        drive(4'd9, 3'd7, 3'd0, 3'd5, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b1000, 8'd0)) begin
            n_fail++; $display("FAIL r5_cleared: got %h expected %h", obs, ex(1, 0, 7, 4'b1000, 8'd0));
        end
        drive(4'd9, 3'd7, 3'd0, 3'd1, 8'd0, 1'b0);
        step();
        n_checks++;
        if (obs !== ex(1, 0, 7, 4'b1000, 8'd0)) begin
            n_fail++; $display("FAIL r1_cleared: got %h expected %h", obs, ex(1, 0, 7, 4'b1000, 8'd0));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        out_ready  = 1'b1;
        test_reset();
        test_back_to_back();
        test_arith();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
